// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID pipeline stage with valid/ready handshake and 2-entry skid buffer
//
// Carries a fetch bundle {pc, LANES instructions, lane mask} from fetch to decode.
// The main entry drives the outputs; the skid entry absorbs one extra bundle so that
// in_ready can come straight from a flop instead of depending on out_ready.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of all held bundles
//   in_valid/in_ready fetch-side handshake (in_ready registered)
//   in_pc/in_instr/in_lane_mask   incoming bundle payload (lane 0 in LSBs)
//   out_valid/out_ready           decode-side handshake
//   out_pc/out_instr/out_lane_mask held bundle payload (NOP payload when invalid)
//   stall_cycles      saturating count of cycles with out_valid & !out_ready
module if_id_skid_stage #(
    parameter int          XLEN      = 64,
    parameter int          ILEN      = 32,
    parameter int          LANES     = 1,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [LANES*ILEN-1:0] in_instr,
    input  logic [LANES-1:0]      in_lane_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [LANES*ILEN-1:0] out_instr,
    output logic [LANES-1:0]      out_lane_mask,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [LANES*ILEN-1:0] NOP_BUNDLE = {LANES{NOP_INSTR}};
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};

    logic                  main_valid;
    logic [XLEN-1:0]       main_pc;
    logic [LANES*ILEN-1:0] main_instr;
    logic [LANES-1:0]      main_mask;

    logic                  skid_valid;
    logic [XLEN-1:0]       skid_pc;
    logic [LANES*ILEN-1:0] skid_instr;
    logic [LANES-1:0]      skid_mask;

    logic [CNT_W-1:0]      stall_q;

    logic accept;
    logic consume;

    // in_ready is the registered complement of skid_valid, so no input or
    // out_ready can reach it combinationally.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid & out_ready;

    assign out_valid     = main_valid;
    assign out_pc        = main_pc;
    assign out_instr     = main_instr;
    assign out_lane_mask = main_mask;
    assign stall_cycles  = stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP_BUNDLE;
            main_mask  <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_BUNDLE;
            skid_mask  <= '0;
        end else if (flush) begin
            // Accepts in this cycle are dropped; a consume is still taken by decode.
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP_BUNDLE;
            main_mask  <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_BUNDLE;
            skid_mask  <= '0;
        end else if (!main_valid) begin
            // EMPTY: a new bundle goes straight to main.
            if (accept) begin
                main_valid <= 1'b1;
                main_pc    <= in_pc;
                main_instr <= in_instr;
                main_mask  <= in_lane_mask;
            end
        end else if (!skid_valid) begin
            // ONE
            if (consume) begin
                if (accept) begin
                    main_pc    <= in_pc;
                    main_instr <= in_instr;
                    main_mask  <= in_lane_mask;
                end else begin
                    main_valid <= 1'b0;
                    main_pc    <= '0;
                    main_instr <= NOP_BUNDLE;
                    main_mask  <= '0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
                skid_mask  <= in_lane_mask;
            end
        end else begin
            // FULL: in_ready is low, so only a consume can move things.
            if (consume) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
                main_mask  <= skid_mask;
                skid_valid <= 1'b0;
                skid_pc    <= '0;
                skid_instr <= NOP_BUNDLE;
                skid_mask  <= '0;
            end
        end
    end

    // Stall counter is independent of flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int LANES = 2;
    localparam int CNT_W = 4;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [LANES*ILEN-1:0] in_instr;
    logic [LANES-1:0]      in_lane_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [LANES*ILEN-1:0] out_instr;
    logic [LANES-1:0]      out_lane_mask;
    logic [CNT_W-1:0]      stall_cycles;

    int checks;
    int failures;

    localparam logic [63:0] NOPS = 64'h00000013_00000013;

    if_id_skid_stage #(
        .XLEN(XLEN), .ILEN(ILEN), .LANES(LANES),
        .NOP_INSTR(32'h00000013), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_lane_mask(out_lane_mask),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic [63:0] ins, input logic [1:0] m);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_instr     = ins;
        in_lane_mask = m;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_lane_mask = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset / idle state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", out_instr, NOPS);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_mask", 64'(out_lane_mask), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);

        // Streaming, one bundle per cycle
        out_ready = 1'b1;
        send(64'h1000, 64'hAAAA0001_11110001, 2'b11);
        tick();
        check("s0_valid", 64'(out_valid), 64'd1);
        check("s0_pc", out_pc, 64'h1000);
        check("s0_instr", out_instr, 64'hAAAA0001_11110001);
        check("s0_mask", 64'(out_lane_mask), 64'd3);
        send(64'h1008, 64'hAAAA0002_11110002, 2'b01);
        tick();
        check("s1_pc", out_pc, 64'h1008);
        check("s1_mask", 64'(out_lane_mask), 64'd1);
        check("s1_in_ready", 64'(in_ready), 64'd1);
        send(64'h1010, 64'hAAAA0003_11110003, 2'b10);
        tick();
        check("s2_pc", out_pc, 64'h1010);
        check("s2_instr", out_instr, 64'hAAAA0003_11110003);
        check("s2_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        tick();
        check("s3_drained", 64'(out_valid), 64'd0);
        check("s3_pc", out_pc, 64'd0);
        check("s3_stall", 64'(stall_cycles), 64'd0);

        // Back-pressure into skid
        out_ready = 1'b0;
        send(64'h2000, 64'h22220000_22220001, 2'b11);
        tick();
        check("bp0_pc", out_pc, 64'h2000);
        check("bp0_in_ready", 64'(in_ready), 64'd1);
        check("bp0_stall", 64'(stall_cycles), 64'd0);
        send(64'h2008, 64'h22220008_22220009, 2'b01);
        tick();
        check("bp1_pc", out_pc, 64'h2000);
        check("bp1_in_ready", 64'(in_ready), 64'd0);
        check("bp1_stall", 64'(stall_cycles), 64'd1);
        send(64'h2010, 64'h22220010_22220011, 2'b11);
        tick();
        check("bp2_pc_stable", out_pc, 64'h2000);
        check("bp2_instr_stable", out_instr, 64'h22220000_22220001);
        check("bp2_stall", 64'(stall_cycles), 64'd2);
        in_valid = 1'b0;
        tick();
        check("bp3_stall", 64'(stall_cycles), 64'd3);
        out_ready = 1'b1;
        tick();
        check("bp4_pc", out_pc, 64'h2008);
        check("bp4_mask", 64'(out_lane_mask), 64'd1);
        check("bp4_in_ready", 64'(in_ready), 64'd1);
        check("bp4_stall", 64'(stall_cycles), 64'd3);
        tick();
        check("bp5_no_2010", 64'(out_valid), 64'd0);

        // Flush while FULL, in_valid present
        out_ready = 1'b0;
        send(64'h2100, 64'h1, 2'b01);
        tick();
        send(64'h2108, 64'h2, 2'b01);
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        check("fl_pre_stall", 64'(stall_cycles), 64'd4);
        flush = 1'b1;
        send(64'h3000, 64'h3, 2'b11);
        tick();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_pc", out_pc, 64'd0);
        check("fl_instr", out_instr, NOPS);
        check("fl_mask", 64'(out_lane_mask), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        check("fl_stall", 64'(stall_cycles), 64'd5);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_no_3000", 64'(out_valid), 64'd0);

        // Flush in ONE with an accepted input: the input is discarded
        out_ready = 1'b0;
        send(64'h3100, 64'h4, 2'b01);
        tick();
        flush = 1'b1;
        send(64'h3200, 64'h5, 2'b01);
        tick();
        check("fl1_valid", 64'(out_valid), 64'd0);
        check("fl1_stall", 64'(stall_cycles), 64'd6);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("fl1_no_3200", 64'(out_valid), 64'd0);

        // Zero lane mask is still a valid bundle
        out_ready = 1'b1;
        send(64'h4000, 64'h6, 2'b00);
        tick();
        check("m0_valid", 64'(out_valid), 64'd1);
        check("m0_pc", out_pc, 64'h4000);
        check("m0_mask", 64'(out_lane_mask), 64'd0);
        in_valid = 1'b0;
        tick();
        check("m0_drained", 64'(out_valid), 64'd0);

        // Counter saturation at 15, unaffected by flush
        out_ready = 1'b0;
        send(64'h5000, 64'h7, 2'b01);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", 64'(stall_cycles), 64'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_flush", 64'(stall_cycles), 64'd15);

        // Asynchronous reset mid-cycle while FULL
        send(64'h6000, 64'h8, 2'b01);
        tick();
        send(64'h6008, 64'h9, 2'b01);
        tick();
        in_valid = 1'b0;
        check("ar_full", 64'(in_ready), 64'd0);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_pc", out_pc, 64'd0);
        check("ar_instr", out_instr, NOPS);
        check("ar_mask", 64'(out_lane_mask), 64'd0);
        check("ar_stall", 64'(stall_cycles), 64'd0);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised IF/ID pipeline stage with a valid/ready handshake and a 2-entry skid buffer, carrying a fetch bundle (PC, LANES instructions and a lane-valid mask) from fetch to decode.
- Replaces write-enable stalling with back-pressure.
- Fully registered ready path, so decode stalls do not create combinational paths into fetch.
- Flush injects NOP bubbles.
- Saturating stall-cycle counter for performance monitoring.

Parameters:
XLEN, 64, PC width in bits
ILEN, 32, instruction width in bits
LANES, 1, instructions per fetch bundle (1..4)
NOP_INSTR, 32'h00000013, encoding placed in every lane when no valid bundle is held (ILEN bits)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held bundles (branch mispredict / exception)
in_valid  input  1  fetch presents a bundle
in_ready  output  1  stage can accept; registered
in_pc  input  XLEN  bundle PC
in_instr  input  LANES*ILEN  instructions; lane 0 in LSBs
in_lane_mask  input  LANES  per-lane valid bits
out_valid  output  1  decode-side bundle valid
out_ready  input  1  decode accepts
out_pc  output  XLEN  held PC
out_instr  output  LANES*ILEN  held instructions
out_lane_mask  output  LANES  held lane mask
stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding {valid, pc, instr, mask}.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- in_ready is a flop, equal to !skid.valid as of the end of the previous cycle. There is no combinational path from in_valid or out_ready to in_ready.
- Occupancy states:
  - EMPTY (main invalid, skid invalid)
  - ONE (main valid)
  - FULL (both valid)
- Transitions, absent flush:
  - EMPTY + accept -> ONE; bundle appears on outputs next cycle (latency 1).
  - ONE + accept + consume -> ONE; main loads the new bundle (throughput 1/cycle).
  - ONE + consume only -> EMPTY.
  - ONE + accept only -> FULL; the new bundle goes to skid; in_ready drops next cycle.
  - FULL + consume -> ONE; skid moves to main; in_ready rises next cycle. No accept is possible in FULL.
- Order is strictly FIFO; no bundle is duplicated or dropped except by flush.
- flush=1 at a clock edge:
  - Both entries are invalidated regardless of the handshakes.
  - An input accepted in the same cycle is discarded.
  - A consume in the same cycle is still considered taken by decode.
  - Next cycle: state EMPTY, in_ready=1.
- While out_valid=0: out_pc=0, out_lane_mask=0, every lane of out_instr = NOP_INSTR. Invalid entries store these values, and flush writes them.
- Payload capture:
  - in_lane_mask is stored unmodified.
  - A bundle accepted with mask 0 is still a valid bundle.
- stall_cycles:
  - Increments by 1 each cycle that out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.
- Reset (asynchronous, any time, including mid-transfer):
  - Both entries are invalid with NOP payload.
  - in_ready=1, out_valid=0, out_pc=0, out_lane_mask=0, out_instr=all NOP, stall_cycles=0.
- Input payload is ignored when in_valid=0. Output payload is stable while out_valid & !out_ready.

Test Plan:
- Reset release, LANES=2, idle → in_ready=1, out_valid=0, out_instr=64'h00000013_00000013, out_pc=0, stall_cycles=0.
- Streaming: out_ready=1; send pc 0x1000, 0x1008, 0x1010 on consecutive cycles → each appears one cycle later, in order; in_ready stays 1.
- Back-pressure: out_ready=0; send 0x2000 then 0x2008 → out holds 0x2000; in_ready=0 from the following cycle; stall_cycles increments each cycle. Raise out_ready → 0x2000 then 0x2008 emerge, and in_ready returns to 1.
- Flush while FULL with a simultaneous in_valid on pc 0x3000 → next cycle out_valid=0, out_pc=0, NOP lanes, in_ready=1; 0x3000 never emerges.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cycles stops at 15; flush leaves it at 15.
- Asynchronous reset asserted mid-cycle while FULL → outputs go to reset values immediately, without waiting for a clock edge.
